// File: rtl/mem_arb_pkg.sv
// Shared types for the I/D cache line arbiter in front of the bmem deserializer.
// State and client encodings, line geometry, and the line-address alignment helper.
package mem_arb_pkg;

  typedef enum logic [2:0] {IDLE, I_RD, D_RD, D_WR, DONE} arb_state_t;
  typedef enum logic {ICACHE, DCACHE} client_t;

  localparam int LINE_BITS   = 256;
  localparam int LINE_OFFSET = 5;

  function automatic logic [31:0] line_align(input logic [31:0] addr);
    return {addr[31:LINE_OFFSET], {LINE_OFFSET{1'b0}}};
  endfunction

endpackage

// File: rtl/cacheline_mem_arbiter.sv
// Single-outstanding arbiter: I-cache reads and D-cache reads/writebacks onto one dfp line port.
// Registered dfp request side, same-cycle combinational response routing back to the owner.
module cacheline_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          i_addr,
  input  logic                 i_read,
  output logic [LINE_BITS-1:0] i_rdata,
  output logic                 i_resp,
  input  logic [31:0]          d_addr,
  input  logic                 d_read,
  input  logic                 d_write,
  input  logic [LINE_BITS-1:0] d_wdata,
  output logic [LINE_BITS-1:0] d_rdata,
  output logic                 d_resp,
  output logic [31:0]          dfp_addr,
  output logic                 dfp_read,
  output logic                 dfp_write,
  output logic [LINE_BITS-1:0] dfp_wdata,
  input  logic [LINE_BITS-1:0] dfp_rdata,
  input  logic                 dfp_resp,
  output logic                 busy,
  output logic                 timeout_err
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  arb_state_t       state, state_n;
  client_t          last_grant, last_grant_n;
  logic [CNT_W-1:0] wait_cnt;
  logic [31:0]      grant_addr;
  logic             grant;
  logic             waiting;

  assign waiting = (state == I_RD) || (state == D_RD) || (state == D_WR);
  assign grant   = (state == IDLE) && (state_n != IDLE);
  assign busy    = (state != IDLE);

  always_comb begin
    state_n      = state;
    last_grant_n = last_grant;
    case (state)
      IDLE: begin
        // Writeback wins outright; competing reads go to whoever was not served last.
        if (d_write)               state_n = D_WR;
        else if (i_read && d_read) state_n = (last_grant == DCACHE) ? I_RD : D_RD;
        else if (i_read)           state_n = I_RD;
        else if (d_read)           state_n = D_RD;
      end
      I_RD, D_RD, D_WR: begin
        if (dfp_resp) begin
          state_n      = DONE;
          last_grant_n = (state == I_RD) ? ICACHE : DCACHE;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign grant_addr = (state_n == I_RD) ? i_addr : d_addr;

  // Response routing is combinational; rst masks it so an aborted grant never completes.
  assign i_resp  = !rst && dfp_resp && (state == I_RD);
  assign d_resp  = !rst && dfp_resp && ((state == D_RD) || (state == D_WR));
  assign i_rdata = i_resp ? dfp_rdata : '0;
  assign d_rdata = (d_resp && (state == D_RD)) ? dfp_rdata : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      last_grant  <= DCACHE;
      dfp_read    <= 1'b0;
      dfp_write   <= 1'b0;
      dfp_addr    <= '0;
      dfp_wdata   <= '0;
      wait_cnt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      state      <= state_n;
      last_grant <= last_grant_n;
      dfp_read   <= (state_n == I_RD) || (state_n == D_RD);
      dfp_write  <= (state_n == D_WR);
      if (grant) begin
        dfp_addr  <= line_align(grant_addr);
        dfp_wdata <= d_wdata;
      end
      // Counter saturates at the limit; the error flag is sticky until rst.
      if (grant) begin
        wait_cnt <= '0;
      end else if (waiting && !dfp_resp && (wait_cnt != CNT_W'(TIMEOUT_CYCLES))) begin
        wait_cnt <= wait_cnt + CNT_W'(1);
        if (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) timeout_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cacheline_mem_arbiter.sv
// Bench for cacheline_mem_arbiter: directed scenarios, then random clients and a random-latency
// deserializer checked against a transaction-level arbitration and line-memory model.
module tb_cacheline_mem_arbiter;

  localparam int TO = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  i_addr, d_addr, dfp_addr;
  logic         i_read, d_read, d_write, i_resp, d_resp;
  logic         dfp_read, dfp_write, dfp_resp, busy, timeout_err;
  logic [255:0] i_rdata, d_rdata, d_wdata, dfp_wdata, dfp_rdata;

  always #5 clk = ~clk;

  cacheline_mem_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .i_addr(i_addr), .i_read(i_read), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_addr(d_addr), .d_read(d_read), .d_write(d_write), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .dfp_addr(dfp_addr), .dfp_read(dfp_read), .dfp_write(dfp_write), .dfp_wdata(dfp_wdata),
    .dfp_rdata(dfp_rdata), .dfp_resp(dfp_resp),
    .busy(busy), .timeout_err(timeout_err)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    i_read = 0; d_read = 0; d_write = 0; dfp_resp = 0;
    i_addr = 0; d_addr = 0; d_wdata = 0; dfp_rdata = 0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // line memory behind the deserializer
  logic [255:0] mem [logic [31:0]];

  function automatic logic [255:0] line_of(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return {8{a ^ 32'hC0DE_F00D}};
  endfunction

  function automatic logic [31:0] rand_addr();
    return 32'h4000_0000 | ($urandom_range(0, 7) << 5) | $urandom_range(0, 31);
  endfunction

  function automatic logic [31:0] al(input logic [31:0] a);
    return {a[31:5], 5'b0};
  endfunction

  // random-phase model state
  bit           act, resp_now, spur, i_out, d_out, done_i, done_d;
  int           kind, exp_kind, lat, last_served, last_resp_cyc, iw, dw, n_done;
  logic [31:0]  taddr, exp_addr;
  logic [255:0] twdata;
  bit           s_ird, s_drd, s_dwr;
  logic [31:0]  s_iaddr, s_daddr;
  logic [255:0] s_wdata;

  localparam logic [255:0] WD = {2{128'h00112233_44556677_8899AABB_CCDDEEFF}};
  localparam logic [255:0] A5 = {32{8'hA5}};

  initial begin
    // reset state
    do_reset();
    chk("rst_busy", busy, 0);
    chk("rst_dfp_read", dfp_read, 0);
    chk("rst_dfp_write", dfp_write, 0);
    chk("rst_dfp_addr", dfp_addr, 0);
    chk("rst_dfp_wdata", dfp_wdata, 0);
    chk("rst_timeout", timeout_err, 0);

    // single I-cache read
    i_addr = 32'h1000_0024; i_read = 1;
    tick();
    chk("t1_dfp_read", dfp_read, 1);
    chk("t1_dfp_write", dfp_write, 0);
    chk("t1_dfp_addr", dfp_addr, 32'h1000_0020);
    chk("t1_busy", busy, 1);
    dfp_rdata = A5; dfp_resp = 1;
    @(negedge clk);
    chk("t1_i_resp", i_resp, 1);
    chk("t1_i_rdata", i_rdata, A5);
    chk("t1_d_resp", d_resp, 0);
    tick();
    dfp_resp = 0; i_read = 0;
    chk("t1_done_read", dfp_read, 0);
    chk("t1_done_busy", busy, 1);
    tick();
    chk("t1_idle_busy", busy, 0);
    dfp_resp = 1;
    @(negedge clk);
    chk("idle_resp_i", i_resp, 0);
    chk("idle_resp_d", d_resp, 0);
    tick();
    dfp_resp = 0;
    chk("idle_resp_busy", busy, 0);

    // simultaneous reads from reset: I first, then D
    do_reset();
    i_addr = 32'h3000_0100; d_addr = 32'h3000_0200; i_read = 1; d_read = 1;
    tick();
    chk("t2_i_first", dfp_addr, 32'h3000_0100);
    dfp_rdata = {8{32'h1234_5678}}; dfp_resp = 1;
    @(negedge clk);
    chk("t2_i_resp", i_resp, 1);
    chk("t2_d_noresp", d_resp, 0);
    tick();
    dfp_resp = 0;
    chk("t2_done_gap", dfp_read, 0);
    tick();
    chk("t2_idle_gap", dfp_read, 0);
    tick();
    chk("t2_d_next_rd", dfp_read, 1);
    chk("t2_d_next_addr", dfp_addr, 32'h3000_0200);
    dfp_rdata = {8{32'h8765_4321}}; dfp_resp = 1;
    @(negedge clk);
    chk("t2_d_resp", d_resp, 1);
    chk("t2_i_noresp", i_resp, 0);
    chk("t2_d_rdata", d_rdata, {8{32'h8765_4321}});
    tick();
    dfp_resp = 0; d_read = 0;
    tick();
    tick();
    chk("t2_i_again", dfp_addr, 32'h3000_0100);
    dfp_resp = 1;
    tick();
    dfp_resp = 0; i_read = 0;
    tick();

    // write beats read on the D side; request fields frozen during the grant
    d_addr = 32'h2000_0040; d_wdata = WD; d_write = 1; d_read = 1;
    tick();
    chk("t3_dfp_write", dfp_write, 1);
    chk("t3_dfp_read", dfp_read, 0);
    chk("t3_addr", dfp_addr, 32'h2000_0040);
    chk("t3_wdata", dfp_wdata, WD);
    for (int k = 0; k < 3; k++) begin
      d_addr = $urandom; d_wdata = {8{$urandom}};
      tick();
      chk("t4_addr_hold", dfp_addr, 32'h2000_0040);
      chk("t4_wdata_hold", dfp_wdata, WD);
    end
    d_addr = 32'h2000_0040; d_wdata = WD;
    dfp_rdata = {8{32'hFFFF_0000}}; dfp_resp = 1;
    @(negedge clk);
    chk("t3_wr_resp", d_resp, 1);
    chk("t3_wr_rdata", d_rdata, 0);
    chk("t3_wr_i_noresp", i_resp, 0);
    tick();
    dfp_resp = 0; d_write = 0;
    tick();
    tick();
    chk("t3_rd_after_wr", dfp_read, 1);
    chk("t3_rd_no_write", dfp_write, 0);
    chk("t3_rd_addr", dfp_addr, 32'h2000_0040);
    dfp_rdata = WD; dfp_resp = 1;
    @(negedge clk);
    chk("t3_rd_rdata", d_rdata, WD);
    tick();
    dfp_resp = 0; d_read = 0;
    tick();

    // timeout
    do_reset();
    i_addr = 32'h7000_0000; i_read = 1;
    tick();
    for (int k = 1; k < TO; k++) tick();
    chk("to_before", timeout_err, 0);
    tick();
    chk("to_set", timeout_err, 1);
    chk("to_busy", busy, 1);
    chk("to_still_waiting", dfp_read, 1);
    for (int k = 0; k < 3; k++) tick();
    chk("to_hold", timeout_err, 1);
    dfp_resp = 1;
    tick();
    dfp_resp = 0; i_read = 0;
    tick();
    chk("to_sticky", timeout_err, 1);
    chk("to_idle", busy, 0);
    do_reset();
    chk("to_rst_clear", timeout_err, 0);

    // reset in the middle of a D read
    d_addr = 32'h5000_0060; d_read = 1;
    tick();
    chk("t6_rd", dfp_read, 1);
    tick();
    rst = 1;
    @(negedge clk);
    chk("t6_rst_noresp", d_resp, 0);
    tick();
    chk("t6_busy", busy, 0);
    chk("t6_dfp_read", dfp_read, 0);
    chk("t6_d_resp", d_resp, 0);
    rst = 0; d_read = 0; i_addr = 32'h6000_0080; i_read = 1;
    tick();
    chk("t6_i_grant", dfp_read, 1);
    chk("t6_i_addr", dfp_addr, 32'h6000_0080);
    dfp_rdata = A5; dfp_resp = 1;
    @(negedge clk);
    chk("t6_i_resp", i_resp, 1);
    tick();
    dfp_resp = 0; i_read = 0;
    tick();

    // random traffic against the transaction model
    do_reset();
    act = 0; i_out = 0; d_out = 0; done_i = 0; done_d = 0;
    last_served = 1; last_resp_cyc = -10; iw = 0; dw = 0; n_done = 0; kind = 0; lat = 0;
    s_ird = 0; s_drd = 0; s_dwr = 0; s_iaddr = 0; s_daddr = 0; s_wdata = 0;
    taddr = 0; twdata = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if ((dfp_read || dfp_write) && !act) begin
        if (s_dwr)              exp_kind = 2;
        else if (s_ird && s_drd) exp_kind = (last_served == 1) ? 0 : 1;
        else if (s_ird)         exp_kind = 0;
        else if (s_drd)         exp_kind = 1;
        else                    exp_kind = -1;
        exp_addr = al((exp_kind == 0) ? s_iaddr : s_daddr);
        chk("r_iss_has_req", exp_kind >= 0, 1);
        chk("r_iss_write", dfp_write, exp_kind == 2);
        chk("r_iss_read", dfp_read, exp_kind != 2);
        chk("r_iss_addr", dfp_addr, exp_addr);
        if (exp_kind == 2) chk("r_iss_wdata", dfp_wdata, s_wdata);
        chk("r_iss_gap", (cyc - last_resp_cyc) >= 3, 1);
        chk("r_iss_busy", busy, 1);
        act = 1; kind = exp_kind; taddr = exp_addr; twdata = s_wdata;
        lat = $urandom_range(0, 3);
      end else if (act) begin
        chk("r_hold_req", dfp_read || dfp_write, 1);
        chk("r_hold_addr", dfp_addr, taddr);
        if (kind == 2) chk("r_hold_wdata", dfp_wdata, twdata);
      end

      resp_now = 0;
      if (act) begin
        if (lat == 0) resp_now = 1;
        else lat--;
      end
      spur = !act && ($urandom_range(0, 5) == 0);
      dfp_resp = resp_now || spur;
      dfp_rdata = (resp_now && kind != 2) ? line_of(taddr) : {8{$urandom}};

      if (done_i) begin i_read = 0; i_out = 0; done_i = 0; end
      if (done_d) begin d_read = 0; d_write = 0; d_out = 0; done_d = 0; end
      if (act && !resp_now && $urandom_range(0, 11) == 0) begin
        if (kind == 0) i_read = 0;
        else if (kind == 1) d_read = 0;
        else d_write = 0;
      end
      if (!i_out && $urandom_range(0, 2) == 0) begin
        i_read = 1; i_addr = rand_addr(); i_out = 1;
      end
      if (!d_out && $urandom_range(0, 2) == 0) begin
        d_addr = rand_addr(); d_wdata = {$urandom, $urandom, $urandom, $urandom,
                                         $urandom, $urandom, $urandom, $urandom};
        if ($urandom_range(0, 1) == 1) d_write = 1; else d_read = 1;
        d_out = 1;
      end
      s_ird = i_read; s_drd = d_read; s_dwr = d_write;
      s_iaddr = i_addr; s_daddr = d_addr; s_wdata = d_wdata;

      @(negedge clk);
      chk("r_i_resp", i_resp, resp_now && kind == 0);
      chk("r_d_resp", d_resp, resp_now && kind != 0);
      if (resp_now && kind == 0) chk("r_i_rdata", i_rdata, line_of(taddr));
      if (resp_now && kind == 1) chk("r_d_rdata", d_rdata, line_of(taddr));
      if (resp_now && kind == 2) chk("r_wr_rdata", d_rdata, 0);
      if (resp_now) begin
        if (kind == 2) mem[taddr] = twdata;
        last_served = (kind == 0) ? 0 : 1;
        last_resp_cyc = cyc;
        act = 0;
        n_done++;
        if (kind == 0) done_i = 1; else done_d = 1;
      end

      iw = i_out ? iw + 1 : 0;
      dw = d_out ? dw + 1 : 0;
      if (iw > 60) begin chk("r_starve_i", iw, 0); iw = 0; end
      if (dw > 60) begin chk("r_starve_d", dw, 0); dw = 0; end
      tick();
    end
    chk("r_no_timeout", timeout_err, 0);
    chk("r_progress", n_done > 200, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
